instr_loader: RTL and testbench

- Writer side of the instruction memory: fills the instruction memory that the fetch path reads, and holds the core in reset until a program image is loaded and checked.
- Accepts a framed byte stream over a valid/ready handshake, for example from a UART receiver or a bench.
- Assembles little-endian 32-bit words and issues single-cycle write strobes to the instruction memory write port.
- Releases the core reset only after the checksum passes.

---
 rtl/loader_pkg.sv | 25 ++
 rtl/byte_packer.sv | 54 +++++
 rtl/instr_loader.sv | 153 +++++++++++++++
 tb/tb_instr_loader.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : loader_pkg
// Description : Shared types and constants for the instruction loader.
// Revision    : 1.0 - initial release
// ============================================================================
package loader_pkg;

    // Loader frame-level states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN0  = 3'd1,
        LEN1  = 3'd2,
        DATA  = 3'd3,
        CHECK = 3'd4,
        DONE  = 3'd5,
        ERROR = 3'd6
    } loader_state_t;

    // Bytes per instruction word and bytes in the length header
    localparam int WORD_BYTES = 4;
    localparam int HDR_BYTES  = 2;

endpackage
`default_nettype wire

// File: rtl/byte_packer.sv
`default_nettype none
// ============================================================================
// Module      : byte_packer
// Description : Assembles little-endian 32-bit words from a byte stream and
//               pulses o_word_valid the cycle after the fourth byte.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_packer (
    input  logic        clk,
    input  logic        rst,          // asynchronous, active-low
    input  logic        i_clr,        // restart at byte index 0
    input  logic        i_en,         // accept i_data this cycle
    input  logic [7:0]  i_data,
    output logic        o_last,       // next accepted byte completes a word
    output logic [31:0] o_word,
    output logic        o_word_valid
);

    logic [1:0]  r_idx;
    logic [23:0] r_shift;
    logic [31:0] r_word;
    logic        r_word_valid;

    // Shift bytes in from the top so the first byte lands in bits [7:0]; the
    // completed word is copied to a holding register so bytes of the next
    // word accepted during the strobe cycle cannot disturb it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx        <= 2'd0;
            r_shift      <= 24'd0;
            r_word       <= 32'd0;
            r_word_valid <= 1'b0;
        end else begin
            r_word_valid <= 1'b0;
            if (i_clr) begin
                r_idx <= 2'd0;
            end else if (i_en) begin
                r_idx <= r_idx + 2'd1;
                if (r_idx == 2'd3) begin
                    r_word       <= {i_data, r_shift};
                    r_word_valid <= 1'b1;
                end else begin
                    r_shift <= {i_data, r_shift[23:8]};
                end
            end
        end
    end

    assign o_last       = (r_idx == 2'd3);
    assign o_word       = r_word;
    assign o_word_valid = r_word_valid;

endmodule
`default_nettype wire

// File: rtl/instr_loader.sv
`default_nettype none
// ============================================================================
// Module      : instr_loader
// Description : Loads a framed, checksummed program image into instruction
//               memory and holds the core in reset until the load succeeds.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_loader
    import loader_pkg::*;
#(
    parameter int          MAX_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,          // asynchronous, active-low
    input  logic             start,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             cpu_rst,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] words_written
);

    loader_state_t    r_state;
    loader_state_t    w_state_next;

    logic [7:0]       r_len_lo;
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] r_words;
    logic [7:0]       r_chk;
    logic [31:0]      r_mem_addr;
    logic             r_done;
    logic             r_err;
    logic             r_cpu_rst;

    logic             w_xfer;
    logic             w_start_ok;
    logic             w_pk_en;
    logic             w_pk_clr;
    logic             w_pk_last;
    logic [15:0]      w_len;
    logic [CNT_W-1:0] w_words_inc;
    logic             w_last_word;

    assign in_ready    = (r_state == LEN0) || (r_state == LEN1) ||
                         (r_state == DATA) || (r_state == CHECK);
    assign w_xfer      = in_valid && in_ready;
    assign w_start_ok  = start && ((r_state == IDLE) || (r_state == DONE) ||
                                   (r_state == ERROR));
    assign w_len       = {in_data, r_len_lo};
    assign w_words_inc = r_words + CNT_W'(1);
    assign w_pk_en     = w_xfer && (r_state == DATA);
    assign w_pk_clr    = w_start_ok || (w_xfer && (r_state == LEN1));
    assign w_last_word = w_pk_last && (w_words_inc == r_len);

    byte_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .i_clr        (w_pk_clr),
        .i_en         (w_pk_en),
        .i_data       (in_data),
        .o_last       (w_pk_last),
        .o_word       (mem_wdata),
        .o_word_valid (mem_we)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; the FSM leaves DATA on the byte that completes the
    // last word, so the CHK byte may already arrive during that word's strobe.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, DONE, ERROR: begin
                if (start) w_state_next = LEN0;
            end
            LEN0: begin
                if (w_xfer) w_state_next = LEN1;
            end
            LEN1: begin
                if (w_xfer) begin
                    if ({16'd0, w_len} > 32'(MAX_WORDS)) w_state_next = ERROR;
                    else if (w_len == 16'd0)             w_state_next = CHECK;
                    else                                 w_state_next = DATA;
                end
            end
            DATA: begin
                if (w_pk_en && w_last_word) w_state_next = CHECK;
            end
            CHECK: begin
                if (w_xfer) w_state_next = (in_data == r_chk) ? DONE : ERROR;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Header, word counter, write address, checksum and registered status
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_len_lo   <= 8'd0;
            r_len      <= '0;
            r_words    <= '0;
            r_chk      <= 8'd0;
            r_mem_addr <= BASE_ADDR;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_cpu_rst  <= 1'b1;
        end else begin
            r_done    <= (w_state_next == DONE);
            r_err     <= (w_state_next == ERROR);
            r_cpu_rst <= (w_state_next != DONE);
            if (w_start_ok) begin
                r_words <= '0;
                r_chk   <= 8'd0;
            end
            if (w_xfer && (r_state == LEN0)) begin
                r_len_lo <= in_data;
            end
            if (w_xfer && (r_state == LEN1)) begin
                r_len      <= CNT_W'(w_len);
                r_mem_addr <= BASE_ADDR;
            end
            if (w_pk_en) begin
                r_chk <= r_chk ^ in_data;
                if (w_pk_last) begin
                    r_mem_addr <= BASE_ADDR + (32'(r_words) * 32'(WORD_BYTES));
                    r_words    <= w_words_inc;
                end
            end
        end
    end

    assign mem_addr      = r_mem_addr;
    assign cpu_rst       = r_cpu_rst;
    assign done          = r_done;
    assign err           = r_err;
    assign words_written = r_words;

endmodule
`default_nettype wire

// File: tb/tb_instr_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_loader
// Description : Self-checking bench for instr_loader with a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_loader;

    localparam int          MAXW = 1024;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_rst;
    logic        done;
    logic        err;
    logic [15:0] words_written;

    int n_checks = 0;
    int n_fail   = 0;

    // Captured memory writes and count of strobes longer than one cycle
    logic [31:0] cap_addr[$];
    logic [31:0] cap_data[$];
    int          wide_we = 0;
    logic        prev_we = 1'b0;

    // Program image for the next frame
    logic [31:0] frame_words[$];

    always #5 clk = ~clk;

    instr_loader #(.MAX_WORDS(MAXW), .BASE_ADDR(BASE), .CNT_W(16)) dut (
        .clk           (clk),
        .rst           (rst_n),
        .start         (start),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .cpu_rst       (cpu_rst),
        .done          (done),
        .err           (err),
        .words_written (words_written)
    );

    // Record every write strobe, sampled away from the active edge
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            cap_addr.push_back(mem_addr);
            cap_data.push_back(mem_wdata);
            if (prev_we) wide_we++;
        end
        prev_we = (mem_we === 1'b1);
    end

    task automatic clear_caps;
        cap_addr.delete();
        cap_data.delete();
        wide_we = 0;
    endtask

    task automatic pulse_start;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Offer one byte, with in_valid asserted on a cycle with probability valid_pct
    task automatic send_byte(input logic [7:0] b, input int valid_pct);
        int guard;
        bit sent;
        guard = 0;
        sent  = 0;
        while (!sent) begin
            @(negedge clk);
            if (int'($urandom_range(99)) < valid_pct) begin
                in_valid = 1'b1;
                in_data  = b;
                if (in_ready) begin
                    @(posedge clk);
                    #1 in_valid = 1'b0;
                    sent = 1;
                end
            end else begin
                in_valid = 1'b0;
            end
            guard++;
            if (!sent && guard > 400) begin
                n_checks++;
                n_fail++;
                $display("FAIL send_byte_timeout: in_ready=%0b, required 1 within 400 cycles", in_ready);
                in_valid = 1'b0;
                return;
            end
        end
    endtask

    // Send header, payload of frame_words and checksum (override if chk_ovr >= 0)
    task automatic send_frame(input int valid_pct, input int chk_ovr, input bit poke_start);
        logic [7:0] bytes[$];
        logic [7:0] chk;
        logic [31:0] w;
        int n;
        n   = frame_words.size();
        chk = 8'h00;
        bytes.push_back(n[7:0]);
        bytes.push_back(n[15:8]);
        foreach (frame_words[i]) begin
            w = frame_words[i];
            for (int k = 0; k < 4; k++) begin
                bytes.push_back(w[7:0]);
                chk = chk ^ w[7:0];
                w   = w >> 8;
            end
        end
        bytes.push_back((chk_ovr < 0) ? chk : chk_ovr[7:0]);
        foreach (bytes[i]) begin
            send_byte(bytes[i], valid_pct);
            if (poke_start && i == 5) pulse_start();
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({in_ready, mem_we, cpu_rst, done, err} !== 5'b00100) begin
            n_fail++;
            $display("FAIL reset_flags: rdy/we/cpu_rst/done/err=%b, required 00100",
                     {in_ready, mem_we, cpu_rst, done, err});
        end
        n_checks++;
        if (mem_addr !== BASE || mem_wdata !== 32'h0 || words_written !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_values: addr=%h wdata=%h ww=%0d, required %h 0 0",
                     mem_addr, mem_wdata, words_written, BASE);
        end
    endtask

    // Fixed two-word frame, good or corrupted checksum
    task automatic test_basic(input int chk_ovr);
        logic [31:0] exp_d [2];
        exp_d[0] = 32'h0050_0013;
        exp_d[1] = 32'h0010_0093;
        frame_words = {exp_d[0], exp_d[1]};
        clear_caps();
        pulse_start();
        send_frame(100, chk_ovr, 1'b0);
        n_checks++;
        if (cap_addr.size() !== 2) begin
            n_fail++;
            $display("FAIL basic_nwrites: got %0d, required 2", cap_addr.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (cap_addr[i] !== BASE + 32'(4 * i) || cap_data[i] !== exp_d[i]) begin
                    n_fail++;
                    $display("FAIL basic_write%0d: addr=%h data=%h, required %h %h",
                             i, cap_addr[i], cap_data[i], BASE + 32'(4 * i), exp_d[i]);
                end
            end
        end
        n_checks++;
        if (chk_ovr < 0) begin
            if ({done, err, cpu_rst, in_ready} !== 4'b1000 || words_written !== 16'd2) begin
                n_fail++;
                $display("FAIL basic_done: done/err/cpu_rst/rdy=%b ww=%0d, required 1000 2",
                         {done, err, cpu_rst, in_ready}, words_written);
            end
        end else begin
            if ({done, err, cpu_rst, in_ready} !== 4'b0110 || words_written !== 16'd2) begin
                n_fail++;
                $display("FAIL badchk_err: done/err/cpu_rst/rdy=%b ww=%0d, required 0110 2",
                         {done, err, cpu_rst, in_ready}, words_written);
            end
        end
    endtask

    task automatic test_overlen;
        clear_caps();
        pulse_start();
        send_byte(8'h01, 100);
        send_byte(8'h04, 100);
        @(negedge clk);
        n_checks++;
        if ({err, done, cpu_rst, in_ready} !== 4'b1010 || cap_addr.size() !== 0) begin
            n_fail++;
            $display("FAIL overlen: err/done/cpu_rst/rdy=%b writes=%0d, required 1010 0",
                     {err, done, cpu_rst, in_ready}, cap_addr.size());
        end
    endtask

    task automatic test_zero_len;
        frame_words.delete();
        clear_caps();
        pulse_start();
        send_frame(100, -1, 1'b0);
        n_checks++;
        if ({done, err, cpu_rst} !== 3'b100 || cap_addr.size() !== 0 || words_written !== 16'd0) begin
            n_fail++;
            $display("FAIL zero_ok: done/err/cpu_rst=%b writes=%0d ww=%0d, required 100 0 0",
                     {done, err, cpu_rst}, cap_addr.size(), words_written);
        end
        pulse_start();
        send_frame(100, 1, 1'b0);
        n_checks++;
        if ({done, err, cpu_rst} !== 3'b011 || cap_addr.size() !== 0) begin
            n_fail++;
            $display("FAIL zero_badchk: done/err/cpu_rst=%b writes=%0d, required 011 0",
                     {done, err, cpu_rst}, cap_addr.size());
        end
    endtask

    // Random images under 50% in_valid, restarted from DONE or ERROR each time
    task automatic test_random_stream;
        int n;
        bit bad;
        for (int it = 0; it < 6; it++) begin
            n   = (it == 0) ? 3 : int'($urandom_range(1, 6));
            bad = (it == 4);
            frame_words.delete();
            for (int i = 0; i < n; i++) frame_words.push_back($urandom);
            clear_caps();
            pulse_start();
            @(negedge clk);
            n_checks++;
            if ({cpu_rst, done, err, in_ready} !== 4'b1001) begin
                n_fail++;
                $display("FAIL rand%0d_restart: cpu_rst/done/err/rdy=%b, required 1001",
                         it, {cpu_rst, done, err, in_ready});
            end
            send_frame(50, bad ? 32'(8'hA5 ^ 8'h5A) : -1, it == 2);
            n_checks++;
            if (cap_addr.size() !== n || wide_we !== 0) begin
                n_fail++;
                $display("FAIL rand%0d_strobes: writes=%0d wide=%0d, required %0d 0",
                         it, cap_addr.size(), wide_we, n);
            end else begin
                for (int i = 0; i < n; i++) begin
                    n_checks++;
                    if (cap_addr[i] !== BASE + 32'(4 * i) || cap_data[i] !== frame_words[i]) begin
                        n_fail++;
                        $display("FAIL rand%0d_write%0d: addr=%h data=%h, required %h %h",
                                 it, i, cap_addr[i], cap_data[i], BASE + 32'(4 * i), frame_words[i]);
                    end
                end
            end
            n_checks++;
            if (words_written !== 16'(n) || done !== !bad || err !== bad || cpu_rst !== bad) begin
                n_fail++;
                $display("FAIL rand%0d_status: ww=%0d done=%b err=%b cpu_rst=%b, required %0d %b %b %b",
                         it, words_written, done, err, cpu_rst, n, !bad, bad, bad);
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] hdr_and_data [7];
        hdr_and_data = '{8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        clear_caps();
        pulse_start();
        foreach (hdr_and_data[i]) send_byte(hdr_and_data[i], 100);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, mem_we, cpu_rst, done, err} !== 5'b00100 || mem_addr !== BASE ||
            mem_wdata !== 32'h0 || words_written !== 16'd0) begin
            n_fail++;
            $display("FAIL midreset_async: rdy/we/cpu_rst/done/err=%b addr=%h wdata=%h ww=%0d, required 00100 %h 0 0",
                     {in_ready, mem_we, cpu_rst, done, err}, mem_addr, mem_wdata, words_written, BASE);
        end
        @(negedge clk);
        rst_n = 1'b1;
        frame_words = {$urandom, $urandom, $urandom};
        clear_caps();
        pulse_start();
        send_frame(100, -1, 1'b0);
        n_checks++;
        if (cap_addr.size() !== 3 || done !== 1'b1 || words_written !== 16'd3) begin
            n_fail++;
            $display("FAIL midreset_reload: writes=%0d done=%b ww=%0d, required 3 1 3",
                     cap_addr.size(), done, words_written);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (cap_addr[i] !== BASE + 32'(4 * i) || cap_data[i] !== frame_words[i]) begin
                    n_fail++;
                    $display("FAIL midreset_write%0d: addr=%h data=%h, required %h %h",
                             i, cap_addr[i], cap_data[i], BASE + 32'(4 * i), frame_words[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic(-1);
        test_basic(0);
        test_overlen();
        test_zero_len();
        test_random_stream();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
